// File: rtl/trace_ctrl_pkg.sv
// Shared types for the trace capture controller.
// Capture FSM states and trigger source selection.
package trace_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        POST,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMM,
        TRIG_TIME,
        TRIG_EXT,
        TRIG_FORCE
    } trig_mode_t;

endpackage

// File: rtl/trace_dec_tick.sv
// Decimation counter: one sample tick every thr+1 enabled cycles.
// clr restarts the count so a new capture always begins at zero.
module trace_dec_tick #(
    parameter int DEC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DEC_WIDTH-1:0] thr,
    output logic                 tick
);

    logic [DEC_WIDTH-1:0] cnt_q;

    // >= keeps the counter from running the full range if thr drops mid-count
    assign tick = en && (cnt_q >= thr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: decimated sampling into a circular trace RAM,
// trigger selection, post-trigger count and optional time stall when done.
module trace_capture_ctrl
    import trace_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int TIME_WIDTH    = 64,
    parameter int DEC_WIDTH     = 24,
    parameter int DT_WIDTH      = 32,
    parameter bit STALL_ON_DONE = 1'b1
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            trig_mode,
    input  logic [TIME_WIDTH-1:0] trig_time,
    input  logic                  ext_trig,
    input  logic                  force_trig,
    input  logic [DEC_WIDTH-1:0]  dec_thr,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [TIME_WIDTH-1:0] emu_time,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  wrapped,
    output logic                  busy,
    output logic                  done,
    output logic [DT_WIDTH-1:0]   dt_req_stall
);

    state_t                state_q, state_nx;
    trig_mode_t            mode;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] post_q;
    logic                  ext_r_q, ext_r2_q;
    logic                  pend_q;
    logic                  tick, tick_en;
    logic                  trig_evt, trig_now;
    logic                  go_pre, wr_en, trig_hit;

    assign mode    = trig_mode_t'(trig_mode);
    assign tick_en = (state_q == PRE) || (state_q == POST);

    trace_dec_tick #(
        .DEC_WIDTH(DEC_WIDTH)
    ) u_dec (
        .clk (emu_clk),
        .rst (emu_rst),
        .clr (go_pre),
        .en  (tick_en),
        .thr (dec_thr),
        .tick(tick)
    );

    always_comb begin
        trig_evt = ((mode == TRIG_EXT) && ext_r_q && !ext_r2_q)
                || ((mode == TRIG_FORCE) && force_trig);
        trig_now = 1'b0;
        unique case (mode)
            TRIG_IMM:  trig_now = 1'b1;
            TRIG_TIME: trig_now = (emu_time >= trig_time);
            default:   trig_now = trig_evt || pend_q;
        endcase
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        go_pre   = 1'b0;
        wr_en    = 1'b0;
        trig_hit = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    go_pre   = 1'b1;
                    state_nx = PRE;
                end
            end
            PRE: begin
                if (tick) begin
                    wr_en = 1'b1;
                    if (trig_now) begin
                        trig_hit = 1'b1;
                        state_nx = (post_count == '0) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (tick) begin
                    wr_en = 1'b1;
                    if (post_q == ADDR_WIDTH'(1)) state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            go_pre   = 1'b0;
            wr_en    = 1'b0;
            trig_hit = 1'b0;
        end
    end

    // post_count is ADDR_WIDTH wide, so it never exceeds DEPTH-1
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            addr_q       <= '0;
            post_q       <= '0;
            ext_r_q      <= 1'b0;
            ext_r2_q     <= 1'b0;
            pend_q       <= 1'b0;
            buf_we       <= 1'b0;
            buf_addr     <= '0;
            trig_addr    <= '0;
            wrapped      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dt_req_stall <= '1;
        end else begin
            ext_r_q  <= ext_trig;
            ext_r2_q <= ext_r_q;
            buf_we   <= wr_en;
            if (go_pre) begin
                addr_q  <= '0;
                wrapped <= 1'b0;
                pend_q  <= 1'b0;
            end else if ((state_q == PRE) && trig_evt) begin
                pend_q <= 1'b1;
            end
            if (wr_en) begin
                buf_addr <= addr_q;
                addr_q   <= addr_q + 1'b1;
                if ((state_q == PRE) && (addr_q == '1)) wrapped <= 1'b1;
            end
            if (trig_hit) begin
                trig_addr <= addr_q;
                post_q    <= post_count;
            end else if (wr_en && (state_q == POST)) begin
                post_q <= post_q - 1'b1;
            end
            busy         <= (state_nx == PRE) || (state_nx == POST);
            done         <= (state_nx == DONE);
            dt_req_stall <= ((state_nx == DONE) && STALL_ON_DONE) ? '0 : '1;
        end
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Randomized scoreboard bench for trace_capture_ctrl (DEPTH=16).
// Expected writes come from tick/trigger arithmetic, checked by a monitor.
module tb_trace_capture_ctrl;

    logic        clk = 1'b0;
    logic        emu_rst;
    logic        arm, abort, ext_trig, force_trig;
    logic [1:0]  trig_mode;
    logic [63:0] trig_time, emu_time;
    logic [7:0]  dec_thr;
    logic [3:0]  post_count;
    logic        buf_we, wrapped, busy, done;
    logic [3:0]  buf_addr, trig_addr;
    logic [31:0] dt_req_stall;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
    } wr_t;

    wr_t exp_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    trace_capture_ctrl #(
        .ADDR_WIDTH(4), .TIME_WIDTH(64), .DEC_WIDTH(8),
        .DT_WIDTH(32), .STALL_ON_DONE(1'b1)
    ) dut (
        .emu_clk(clk), .emu_rst(emu_rst), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_time(trig_time), .ext_trig(ext_trig),
        .force_trig(force_trig), .dec_thr(dec_thr), .post_count(post_count),
        .emu_time(emu_time), .buf_we(buf_we), .buf_addr(buf_addr),
        .trig_addr(trig_addr), .wrapped(wrapped), .busy(busy), .done(done),
        .dt_req_stall(dt_req_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        wr_t e;
        #1;
        if (buf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d cyc=%0d, required no write",
                         buf_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                if (buf_addr !== e.addr || cyc != e.cyc)
                begin
                    errors++;
                    $display("FAIL write: addr=%0d cyc=%0d, required addr=%0d cyc=%0d",
                             buf_addr, cyc, e.addr, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic int jt(input int k, input int thr);
        return k * (thr + 1) + thr;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_buf_we", 64'(buf_we), 0);
        chk("rst_buf_addr", 64'(buf_addr), 0);
        chk("rst_trig_addr", 64'(trig_addr), 0);
        chk("rst_wrapped", 64'(wrapped), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
    endtask

    // p: trigger offset in PRE cycles (time threshold, ext rise start, force cycle)
    // cut: PRE cycle at which abort (or reset if use_rst) is applied, -1 for none
    task automatic run(input int mode, input int thr, input int post, input int p,
                       input int len, input int cut, input bit use_rst);
        int  c, kt, n, t, j, budget;
        bit  cutdone;
        wr_t w;
        @(negedge clk);
        c          = cyc;
        trig_mode  = 2'(mode);
        dec_thr    = 8'(thr);
        post_count = 4'(post);
        trig_time  = 64'(c + 1 + p);
        emu_time   = 64'(c);
        force_trig = 1'b0;
        ext_trig   = 1'b0;
        arm        = 1'b1;
        kt = 0;
        if (mode != 0) begin
            while (jt(kt, thr) < ((mode == 2) ? p + 1 : p)) kt++;
        end
        n = kt + 1 + post;
        for (int k = 0; k < n; k++) begin
            if (cut < 0 || jt(k, thr) < cut) begin
                w.cyc  = c + 2 + jt(k, thr);
                w.addr = 4'(k % 16);
                exp_q.push_back(w);
            end
        end
        budget  = (kt + post + 3) * (thr + 1) + 20;
        cutdone = 1'b0;
        t       = 0;
        forever begin
            @(negedge clk);
            arm = 1'b0;
            if (cutdone) begin
                abort   = 1'b0;
                emu_rst = 1'b0;
                break;
            end
            if (done === 1'b1) break;
            if (t > budget) begin
                checks++;
                errors++;
                $display("FAIL timeout: no done after %0d cycles, required done", t);
                break;
            end
            j = cyc - c - 1;
            if (j == 0) begin
                chk("arm_busy", 64'(busy), 1);
                chk("arm_done", 64'(done), 0);
                chk("arm_wrapped", 64'(wrapped), 0);
                chk("arm_dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
            end
            emu_time   = 64'(cyc);
            force_trig = (mode == 3) && (j == p);
            ext_trig   = (mode == 2) && (j >= p) && (j < p + len);
            if (cut >= 0 && j == cut) begin
                cutdone = 1'b1;
                if (use_rst) begin
                    emu_rst = 1'b1;
                    #1;
                    chk_reset_vals();
                end else begin
                    abort = 1'b1;
                end
            end
            t++;
        end
        force_trig = 1'b0;
        ext_trig   = 1'b0;
        chk("queue_drained", 64'(exp_q.size()), 0);
        exp_q.delete();
        if (cutdone) begin
            chk("cut_busy", 64'(busy), 0);
            chk("cut_done", 64'(done), 0);
            chk("cut_dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
        end else begin
            chk("trig_addr", 64'(trig_addr), 64'(kt % 16));
            chk("wrapped", 64'(wrapped), 64'(kt >= 15));
            chk("done_dt", 64'(dt_req_stall), 0);
            chk("done_busy", 64'(busy), 0);
            chk("done_flag", 64'(done), 1);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int m, th, po, pp, ln, ct;
        bit ur;
        emu_rst    = 1'b1;
        arm        = 1'b0;
        abort      = 1'b0;
        ext_trig   = 1'b0;
        force_trig = 1'b0;
        trig_mode  = 2'd0;
        trig_time  = '0;
        emu_time   = '0;
        dec_thr    = '0;
        post_count = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        emu_rst = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 0, 3, 0, 0, -1, 1'b0);
        run(1, 3, 2, 13, 0, -1, 1'b0);
        run(3, 0, 2, 20, 0, -1, 1'b0);
        run(2, 7, 4, 3, 20, -1, 1'b0);
        run(0, 1, 0, 0, 0, -1, 1'b0);
        run(1, 0, 15, 30, 0, -1, 1'b0);
        run(0, 2, 10, 0, 0, 11, 1'b0);
        run(3, 1, 5, 1000, 0, 9, 1'b1);
        run(2, 0, 2, 5, 1, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            m  = $urandom_range(0, 3);
            th = $urandom_range(0, 4);
            po = $urandom_range(0, 15);
            pp = $urandom_range(0, 30);
            ln = $urandom_range(1, 40);
            ct = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : -1;
            ur = (ct >= 0) && ($urandom_range(0, 1) == 1);
            run(m, th, po, pp, ln, ct, ur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
